// File: rtl/link_tx_scheduler.sv
// Purpose    : arbitrates power-on reply, audio sample requests and keyboard/mouse events
//              into one 40-bit packet at a time for the mon_clk link sender.
// Latency    : request sampled at edge k (idle, nothing else pending) -> out_valid after edge k+1.
// Backpressure: out_valid/out_data held stable until out_ready; GAP_CYCLES+1 idle cycles follow each accept.
//
// Ports:
//   mon_clk, reset      : link clock, synchronous active-high reset
//   power_on_req        : pulse, request power-on reply (coalesces)
//   audio_req_mode/tick : audio sample-request mode level / one request due pulse
//   kb_valid, kb_data   : keyboard/mouse event, kb_data[16]=is_mouse, [15:0]=code
//   out_ready/out_valid/out_data : packet handshake to the serial sender
//   kb_drop             : pulse, a keyboard event was lost
//   audio_overrun       : saturating count of audio ticks lost while a request was pending
//
// Build option KB_FIFO_EN: replaces the single-entry keyboard register with a KB_DEPTH FIFO.
module link_tx_scheduler #(
   parameter int GAP_CYCLES     = 16,
   parameter int MAX_AUDIO_WINS = 4
`ifdef KB_FIFO_EN
   ,
   parameter int KB_DEPTH       = 4
`endif
) (
   input  logic        mon_clk,
   input  logic        reset,
   input  logic        power_on_req,
   input  logic        audio_req_mode,
   input  logic        audio_req_tick,
   input  logic        kb_valid,
   input  logic [16:0] kb_data,
   input  logic        out_ready,
   output logic [39:0] out_data,
   output logic        out_valid,
   output logic        kb_drop,
   output logic [7:0]  audio_overrun
);

   // Gap counter is loaded with GAP_CYCLES-1 on accept and the FSM leaves GAP when it
   // reads 0; together with the IDLE decision cycle this yields GAP_CYCLES+1 idle cycles.
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

   localparam int WW = (MAX_AUDIO_WINS > 0) ? $clog2(MAX_AUDIO_WINS + 1) : 1;
   localparam logic [WW-1:0] WIN_MAX = WW'(MAX_AUDIO_WINS);

   localparam logic [7:0] OP_PON   = 8'hC0;
   localparam logic [7:0] OP_AUD   = 8'h07;
   localparam logic [7:0] OP_KEY   = 8'hC5;
   localparam logic [7:0] OP_MOUSE = 8'hC6;

   typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;
   typedef enum logic [1:0] {SRC_PON, SRC_AUD, SRC_KB} src_t;

   state_t          state, next_state;
   src_t            grant_src, sel_src;
   logic            load, accept;
   logic            pon_pend, aud_pend;
   logic [GW-1:0]   gap_cnt;
   logic [WW-1:0]   win_cnt;
   logic [7:0]      out_op, sel_op;
   logic [15:0]     out_pay, sel_pay;
   logic            kb_avail;
   logic [16:0]     kb_head;
   logic            kb_pop, pon_clr, aud_granted;

   assign out_data    = {out_op, out_pay, 16'h0000};
   assign pon_clr     = accept && (grant_src == SRC_PON);
   assign aud_granted = accept && (grant_src == SRC_AUD);
   assign kb_pop      = accept && (grant_src == SRC_KB);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge mon_clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      sel_src    = SRC_PON;
      load       = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (pon_pend || aud_pend || kb_avail) begin
               load       = 1'b1;
               next_state = PRESENT;
               if (pon_pend)
                  sel_src = SRC_PON;
               // Keyboard is starved out only up to MAX_AUDIO_WINS audio grants in a row.
               else if (kb_avail && (!aud_pend || win_cnt == WIN_MAX))
                  sel_src = SRC_KB;
               else
                  sel_src = SRC_AUD;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               accept     = 1'b1;
               next_state = GAP;
            end
         end
         GAP: begin
            if (gap_cnt == '0) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      sel_op  = OP_PON;
      sel_pay = 16'h0000;
      case (sel_src)
         SRC_AUD: sel_op = OP_AUD;
         SRC_KB: begin
            sel_op  = kb_head[16] ? OP_MOUSE : OP_KEY;
            sel_pay = kb_head[15:0];
         end
         default: sel_op = OP_PON;
      endcase
   end

   // ---------------------------------------------------------------- packet / counters
   always_ff @(posedge mon_clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_op    <= '0;
         out_pay   <= '0;
         grant_src <= SRC_PON;
         gap_cnt   <= '0;
         win_cnt   <= '0;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            out_op    <= sel_op;
            out_pay   <= sel_pay;
            grant_src <= sel_src;
         end else if (accept) begin
            out_valid <= 1'b0;
         end

         if (accept) begin
            gap_cnt <= GAP_LOAD;
            if (grant_src == SRC_AUD) begin
               if (win_cnt != WIN_MAX) win_cnt <= win_cnt + 1'b1;
            end else begin
               win_cnt <= '0;
            end
         end else if (state == GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- request capture
   // A new request in the same cycle as the clear of its source wins, so nothing is lost.
   always_ff @(posedge mon_clk) begin
      if (reset) begin
         pon_pend      <= 1'b0;
         aud_pend      <= 1'b0;
         audio_overrun <= 8'd0;
      end else begin
         if (power_on_req)  pon_pend <= 1'b1;
         else if (pon_clr)  pon_pend <= 1'b0;

         if (!audio_req_mode)     aud_pend <= 1'b0;
         else if (audio_req_tick) aud_pend <= 1'b1;
         else if (aud_granted)    aud_pend <= 1'b0;

         if (audio_req_mode && audio_req_tick && aud_pend && !aud_granted &&
             audio_overrun != 8'hFF)
            audio_overrun <= audio_overrun + 8'd1;
      end
   end

   // ---------------------------------------------------------------- keyboard store
`ifdef KB_FIFO_EN
   localparam int AW = $clog2(KB_DEPTH);

   logic [16:0] kb_mem [KB_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        kb_full, kb_push;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign kb_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign kb_avail = (wr_ptr != rd_ptr);
   assign kb_push  = kb_valid && (!kb_full || kb_pop);
   assign kb_head  = kb_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge mon_clk) begin
      if (kb_push) kb_mem[wr_ptr[AW-1:0]] <= kb_data;
   end

   always_ff @(posedge mon_clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         kb_drop <= 1'b0;
      end else begin
         kb_drop <= kb_valid && kb_full && !kb_pop;
         if (kb_push) wr_ptr <= wr_ptr + 1'b1;
         if (kb_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end
`else
   logic        kb_full;
   logic [16:0] kb_reg;

   assign kb_avail = kb_full;
   assign kb_head  = kb_reg;

   // Newest event always wins; an unsent older one is reported through kb_drop.
   always_ff @(posedge mon_clk) begin
      if (reset) begin
         kb_full <= 1'b0;
         kb_reg  <= '0;
         kb_drop <= 1'b0;
      end else begin
         kb_drop <= kb_valid && kb_full && !kb_pop;
         if (kb_valid) begin
            kb_reg  <= kb_data;
            kb_full <= 1'b1;
         end else if (kb_pop) begin
            kb_full <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_link_tx_scheduler.sv
module tb_link_tx_scheduler;

   logic        mon_clk = 1'b0;
   logic        reset;
   logic        power_on_req;
   logic        audio_req_mode;
   logic        audio_req_tick;
   logic        kb_valid;
   logic [16:0] kb_data;
   logic        out_ready;
   logic [39:0] out_data;
   logic        out_valid;
   logic        kb_drop;
   logic [7:0]  audio_overrun;

   int errors = 0;
   int checks = 0;
   logic [39:0] exp_q[$];

   link_tx_scheduler dut (
      .mon_clk        (mon_clk),
      .reset          (reset),
      .power_on_req   (power_on_req),
      .audio_req_mode (audio_req_mode),
      .audio_req_tick (audio_req_tick),
      .kb_valid       (kb_valid),
      .kb_data        (kb_data),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .kb_drop        (kb_drop),
      .audio_overrun  (audio_overrun)
   );

   always #5 mon_clk = ~mon_clk;

   task automatic step();
      @(posedge mon_clk);
      #1;
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_dat(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Wait for a packet, compare against the scoreboard head, hold it for 'stall'
   // cycles, then accept. 'zeros' returns how many out_valid=0 samples preceded it.
   task automatic recv(input int stall, input bit tick_acc, output int zeros);
      logic [39:0] exp;
      zeros = 0;
      while (out_valid !== 1'b1 && zeros < 200) begin
         step();
         zeros++;
      end
      if (out_valid !== 1'b1) begin
         chk_bit("recv_timeout", out_valid, 1'b1);
         return;
      end
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL unexpected_pkt observed=%h expected=none", out_data);
         return;
      end
      exp = exp_q.pop_front();
      chk_dat("pkt_data", out_data, exp);
      for (int i = 0; i < stall; i++) begin
         step();
         chk_bit("hold_valid", out_valid, 1'b1);
         chk_dat("hold_data", out_data, exp);
      end
      out_ready = 1'b1;
      if (tick_acc) audio_req_tick = 1'b1;
      step();
      out_ready      = 1'b0;
      audio_req_tick = 1'b0;
      chk_bit("accept_drop_valid", out_valid, 1'b0);
   endtask

   task automatic quiet(input int n, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      chk_bit(tag, seen, 1'b0);
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      power_on_req   = 1'b0;
      audio_req_mode = 1'b0;
      audio_req_tick = 1'b0;
      kb_valid       = 1'b0;
      kb_data        = '0;
      out_ready      = 1'b0;
      step();
      step();
      chk_bit("rst_valid", out_valid, 1'b0);
      chk_dat("rst_data", out_data, 40'h0);
      chk_bit("rst_kb_drop", kb_drop, 1'b0);
      chk_int("rst_overrun", int'(audio_overrun), 0);
      reset = 1'b0;
      step();
   endtask

   initial begin
      int zeros;

      // ---- 1: power-on reply, latency, stall stability, gap
      do_reset();
      repeat (8) step();
      chk_bit("idle_no_valid", out_valid, 1'b0);
      power_on_req = 1'b1;
      exp_q.push_back(40'hC0_0000_0000);
      step();
      power_on_req = 1'b0;
      chk_bit("pon_not_yet", out_valid, 1'b0);
      recv(5, 1'b0, zeros);
      chk_int("pon_latency", zeros, 1);
      quiet(16, "pon_gap_quiet");

      // ---- 2: simultaneous requests, priority order and gap length
      do_reset();
      audio_req_mode = 1'b1;
      power_on_req   = 1'b1;
      audio_req_tick = 1'b1;
      kb_valid       = 1'b1;
      kb_data        = 17'h0_0042;
      exp_q.push_back(40'hC0_0000_0000);
      exp_q.push_back(40'h07_0000_0000);
      exp_q.push_back(40'hC5_0042_0000);
      step();
      power_on_req   = 1'b0;
      audio_req_tick = 1'b0;
      kb_valid       = 1'b0;
      recv(0, 1'b0, zeros);
      chk_int("prio_first_latency", zeros, 1);
      recv(0, 1'b0, zeros);
      chk_int("gap_len_1", zeros, 17);
      recv(2, 1'b0, zeros);
      chk_int("gap_len_2", zeros, 17);
      quiet(30, "prio_done_quiet");
      chk_int("prio_overrun", int'(audio_overrun), 0);

      // ---- 3: audio win limit lets the waiting mouse event through after 4 audio grants
      do_reset();
      audio_req_mode = 1'b1;
      audio_req_tick = 1'b1;
      kb_valid       = 1'b1;
      kb_data        = 17'h1_0123;
      for (int i = 0; i < 4; i++) exp_q.push_back(40'h07_0000_0000);
      exp_q.push_back(40'hC6_0123_0000);
      exp_q.push_back(40'h07_0000_0000);
      step();
      audio_req_tick = 1'b0;
      kb_valid       = 1'b0;
      for (int i = 0; i < 4; i++) begin
         recv(0, 1'b1, zeros);   // tick on accept keeps audio pending
      end
      recv(0, 1'b0, zeros);
      chk_int("kb_after_wins_gap", zeros, 17);
      recv(0, 1'b0, zeros);
      quiet(30, "wins_done_quiet");
      chk_int("wins_overrun", int'(audio_overrun), 0);

      // ---- 4: audio overrun counting and saturation
      do_reset();
      audio_req_mode = 1'b1;
      audio_req_tick = 1'b1;
      exp_q.push_back(40'h07_0000_0000);
      step();
      audio_req_tick = 1'b0;
      step();
      chk_bit("aud_presented", out_valid, 1'b1);
      audio_req_tick = 1'b1;
      step();
      audio_req_tick = 1'b0;
      chk_int("overrun_one", int'(audio_overrun), 1);
      recv(2, 1'b0, zeros);
      quiet(40, "one_aud_pkt");
      chk_int("overrun_keep", int'(audio_overrun), 1);
      audio_req_tick = 1'b1;
      exp_q.push_back(40'h07_0000_0000);
      step();
      audio_req_tick = 1'b0;
      step();
      audio_req_tick = 1'b1;
      repeat (300) step();
      audio_req_tick = 1'b0;
      chk_int("overrun_sat", int'(audio_overrun), 255);
      recv(0, 1'b0, zeros);
      quiet(30, "sat_one_pkt");
      audio_req_mode = 1'b0;
      audio_req_tick = 1'b1;
      step();
      audio_req_tick = 1'b0;
      quiet(30, "mode_off_ignored");
      chk_int("overrun_sat_hold", int'(audio_overrun), 255);

      // ---- 5: keyboard store overflow while the link is stalled
      do_reset();
      power_on_req = 1'b1;
      exp_q.push_back(40'hC0_0000_0000);
      step();
      power_on_req = 1'b0;
      step();
      chk_bit("kb_stall_valid", out_valid, 1'b1);
`ifdef KB_FIFO_EN
      for (int v = 1; v <= 5; v++) begin
         kb_valid = 1'b1;
         kb_data  = 17'(v);
         step();
         chk_bit($sformatf("kb_drop_push%0d", v), kb_drop, (v == 5));
      end
      kb_valid = 1'b0;
      step();
      chk_bit("kb_drop_clear", kb_drop, 1'b0);
      for (int v = 1; v <= 4; v++) exp_q.push_back({8'hC5, 16'(v), 16'h0000});
      for (int i = 0; i < 5; i++) recv(0, 1'b0, zeros);
`else
      kb_valid = 1'b1;
      kb_data  = 17'h0_0011;
      step();
      chk_bit("kb_drop_first", kb_drop, 1'b0);
      kb_data = 17'h0_0022;
      step();
      chk_bit("kb_drop_second", kb_drop, 1'b1);
      kb_valid = 1'b0;
      step();
      chk_bit("kb_drop_clear", kb_drop, 1'b0);
      exp_q.push_back(40'hC5_0022_0000);
      recv(0, 1'b0, zeros);
      recv(0, 1'b0, zeros);
`endif
      quiet(30, "kb_done_quiet");

      // ---- 6: reset while presenting discards the packet and all pending requests
      do_reset();
      audio_req_mode = 1'b1;
      power_on_req   = 1'b1;
      audio_req_tick = 1'b1;
      kb_valid       = 1'b1;
      kb_data        = 17'h0_0055;
      step();
      power_on_req   = 1'b0;
      audio_req_tick = 1'b0;
      kb_valid       = 1'b0;
      step();
      chk_bit("pre_rst_present", out_valid, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_bit("mid_rst_valid", out_valid, 1'b0);
      chk_dat("mid_rst_data", out_data, 40'h0);
      quiet(40, "post_rst_quiet");
      power_on_req = 1'b1;
      exp_q.push_back(40'hC0_0000_0000);
      step();
      power_on_req = 1'b0;
      recv(0, 1'b0, zeros);
      chk_int("post_rst_latency", zeros, 1);
      quiet(30, "post_rst_done");
      chk_int("sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
